// File: rtl/stopwatch_ctrl_if.sv
// Button, live-digit and display bundle between the stopwatch controller and its surroundings.
// The master side drives buttons and live digits; the slave side is the controller.
interface stopwatch_ctrl_if #(
    parameter int DIGIT_W = 4
);
    logic               btn_ss;
    logic               btn_lr;
    logic [DIGIT_W-1:0] live0;
    logic [DIGIT_W-1:0] live1;
    logic [DIGIT_W-1:0] live2;
    logic [DIGIT_W-1:0] live3;
    logic               run;
    logic               sw_clear;
    logic [DIGIT_W-1:0] disp0;
    logic [DIGIT_W-1:0] disp1;
    logic [DIGIT_W-1:0] disp2;
    logic [DIGIT_W-1:0] disp3;
    logic               lap_active;
    logic [1:0]         state_o;

    modport master (
        output btn_ss, btn_lr, live0, live1, live2, live3,
        input  run, sw_clear, disp0, disp1, disp2, disp3, lap_active, state_o
    );

    modport slave (
        input  btn_ss, btn_lr, live0, live1, live2, live3,
        output run, sw_clear, disp0, disp1, disp2, disp3, lap_active, state_o
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/stop and lap/reset sequencer for the 4-digit stopwatch, with display freeze during a lap.
// Optional auto-stop at 59.99 s is enabled by defining STOPWATCH_MAX_STOP_EN.
module stopwatch_ctrl #(
    parameter int DIGIT_W      = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ss_hist_q, ss_hist_d;
    logic               lr_hist_q, lr_hist_d;
    logic [3:0]         clr_cnt_q, clr_cnt_d;
    logic [DIGIT_W-1:0] held_q [4];
    logic [DIGIT_W-1:0] held_d [4];
    logic [DIGIT_W-1:0] live_w [4];
    logic [DIGIT_W-1:0] disp_w [4];

    logic ss_press;
    logic lr_press;
    logic clearing;

    assign live_w[0] = sw.live0;
    assign live_w[1] = sw.live1;
    assign live_w[2] = sw.live2;
    assign live_w[3] = sw.live3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_disp
            assign disp_w[gi] = (state_q == LAP) ? held_q[gi] : live_w[gi];
        end
    endgenerate

    assign sw.disp0      = disp_w[0];
    assign sw.disp1      = disp_w[1];
    assign sw.disp2      = disp_w[2];
    assign sw.disp3      = disp_w[3];
    assign sw.run        = (state_q == RUNNING) || (state_q == LAP);
    assign sw.lap_active = (state_q == LAP);
    assign sw.state_o    = state_q;
    assign sw.sw_clear   = clearing;

    assign ss_press = sw.btn_ss & ~ss_hist_q;
    assign lr_press = sw.btn_lr & ~lr_hist_q;
    assign clearing = (clr_cnt_q != 4'd0);

`ifdef STOPWATCH_MAX_STOP_EN
    logic at_max;
    assign at_max = (sw.live3 == DIGIT_W'(5)) && (sw.live2 == DIGIT_W'(9)) &&
                    (sw.live1 == DIGIT_W'(9)) && (sw.live0 == DIGIT_W'(9));
`endif

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        ss_hist_d = sw.btn_ss;
        lr_hist_d = sw.btn_lr;
        clr_cnt_d = clearing ? (clr_cnt_q - 4'd1) : 4'd0;

        // Presses during a clear are dropped outright; btn_ss wins a simultaneous press.
        if (!clearing) begin
            case (state_q)
                IDLE: begin
                    if (ss_press)      state_d = RUNNING;
                    else if (lr_press) clr_cnt_d = 4'(CLEAR_CYCLES);
                end
                RUNNING: begin
                    if (ss_press) begin
                        state_d = STOPPED;
                    end else if (lr_press) begin
                        state_d = LAP;
                        held_d  = live_w;
                    end
                end
                LAP: begin
                    if (ss_press)      state_d = STOPPED;
                    else if (lr_press) state_d = RUNNING;
                end
                STOPPED: begin
                    if (ss_press) begin
                        state_d = RUNNING;
                    end else if (lr_press) begin
                        state_d   = IDLE;
                        clr_cnt_d = 4'(CLEAR_CYCLES);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef STOPWATCH_MAX_STOP_EN
        // Auto-stop overrides any button activity in the same cycle, including a lap capture.
        if (((state_q == RUNNING) || (state_q == LAP)) && at_max) begin
            state_d = STOPPED;
            held_d  = held_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_hist_q <= 1'b1;
            lr_hist_q <= 1'b1;
            clr_cnt_q <= 4'd0;
            for (int i = 0; i < 4; i++) held_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ss_hist_q <= ss_hist_d;
            lr_hist_q <= lr_hist_d;
            clr_cnt_q <= clr_cnt_d;
            for (int i = 0; i < 4; i++) held_q[i] <= held_d[i];
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: button sequencing, lap freeze, clear timing, async reset, wrap/auto-stop.
module tb_stopwatch_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    stopwatch_ctrl_if #(.DIGIT_W(4)) sw_if ();

    stopwatch_ctrl #(
        .DIGIT_W      (4),
        .CLEAR_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("  ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_live(input logic [15:0] v);
        sw_if.live3 = v[15:12];
        sw_if.live2 = v[11:8];
        sw_if.live1 = v[7:4];
        sw_if.live0 = v[3:0];
    endtask

    function automatic logic [15:0] disp_all();
        return {sw_if.disp3, sw_if.disp2, sw_if.disp1, sw_if.disp0};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        sw_if.btn_ss = 1'b1;
        sw_if.btn_lr = 1'b0;
        set_live(16'h0000);

        // Reset held with btn_ss high
        tick(); tick();
        check("rst_state", 32'(sw_if.state_o), 32'd0);
        check("rst_run", 32'(sw_if.run), 32'd0);
        check("rst_clear", 32'(sw_if.sw_clear), 32'd0);
        check("rst_lap", 32'(sw_if.lap_active), 32'd0);
        reset = 1'b0;
        tick();
        check("held_btn_no_press", 32'(sw_if.state_o), 32'd0);
        sw_if.btn_ss = 1'b0;
        tick();
        sw_if.btn_ss = 1'b1;
        #1;
        check("pre_edge_state", 32'(sw_if.state_o), 32'd0);
        tick();
        check("start_state", 32'(sw_if.state_o), 32'd1);
        check("start_run", 32'(sw_if.run), 32'd1);
        sw_if.btn_ss = 1'b0;

        // Lap freeze
        set_live(16'h0123);
        tick();
        sw_if.btn_lr = 1'b1;
        tick();
        check("lap_state", 32'(sw_if.state_o), 32'd2);
        check("lap_active", 32'(sw_if.lap_active), 32'd1);
        check("lap_disp", 32'(disp_all()), 32'h0123);
        set_live(16'h0150);
        tick();
        check("lap_disp_frozen", 32'(disp_all()), 32'h0123);
        check("lap_run", 32'(sw_if.run), 32'd1);
        sw_if.btn_lr = 1'b0;
        tick();
        sw_if.btn_lr = 1'b1;
        tick();
        check("unlap_state", 32'(sw_if.state_o), 32'd1);
        check("unlap_lap", 32'(sw_if.lap_active), 32'd0);
        check("unlap_disp", 32'(disp_all()), 32'h0150);
        sw_if.btn_lr = 1'b0;
        tick();

        // Stop, then clear with a start press ignored during the clear
        sw_if.btn_ss = 1'b1;
        tick();
        check("stop_state", 32'(sw_if.state_o), 32'd3);
        check("stop_run", 32'(sw_if.run), 32'd0);
        sw_if.btn_ss = 1'b0;
        tick();
        sw_if.btn_lr = 1'b1;
        tick();
        check("clr_state", 32'(sw_if.state_o), 32'd0);
        check("clr_c1", 32'(sw_if.sw_clear), 32'd1);
        sw_if.btn_lr = 1'b0;
        sw_if.btn_ss = 1'b1;
        tick();
        check("clr_c2", 32'(sw_if.sw_clear), 32'd1);
        check("clr_ss_ignored", 32'(sw_if.state_o), 32'd0);
        tick();
        check("clr_done", 32'(sw_if.sw_clear), 32'd0);
        check("clr_no_queue", 32'(sw_if.state_o), 32'd0);
        sw_if.btn_ss = 1'b0;
        tick();

        // Simultaneous presses in RUNNING: start/stop wins
        sw_if.btn_ss = 1'b1;
        tick();
        check("run2_state", 32'(sw_if.state_o), 32'd1);
        sw_if.btn_ss = 1'b0;
        tick();
        sw_if.btn_ss = 1'b1;
        sw_if.btn_lr = 1'b1;
        tick();
        check("both_state", 32'(sw_if.state_o), 32'd3);
        check("both_lap", 32'(sw_if.lap_active), 32'd0);
        sw_if.btn_ss = 1'b0;
        sw_if.btn_lr = 1'b0;
        tick();

        // Async reset in the middle of a lap
        sw_if.btn_ss = 1'b1;
        tick();
        sw_if.btn_ss = 1'b0;
        set_live(16'h0042);
        tick();
        sw_if.btn_lr = 1'b1;
        tick();
        check("lap42_disp", 32'(disp_all()), 32'h0042);
        set_live(16'h0100);
        #2;
        reset = 1'b1;
        #1;
        check("arst_run", 32'(sw_if.run), 32'd0);
        check("arst_lap", 32'(sw_if.lap_active), 32'd0);
        check("arst_clear", 32'(sw_if.sw_clear), 32'd0);
        check("arst_disp_live", 32'(disp_all()), 32'h0100);
        check("arst_held", 32'({dut.held_q[3], dut.held_q[2], dut.held_q[1], dut.held_q[0]}), 32'h0000);
        sw_if.btn_lr = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Wrap at 59.99
        sw_if.btn_ss = 1'b1;
        tick();
        check("run3_state", 32'(sw_if.state_o), 32'd1);
        sw_if.btn_ss = 1'b0;
        set_live(16'h5998);
        tick();
        check("at5998_state", 32'(sw_if.state_o), 32'd1);
        set_live(16'h5999);
        tick();
`ifdef STOPWATCH_MAX_STOP_EN
        check("autostop_state", 32'(sw_if.state_o), 32'd3);
        check("autostop_run", 32'(sw_if.run), 32'd0);
`else
        check("wrap_state", 32'(sw_if.state_o), 32'd1);
        set_live(16'h0000);
        tick();
        check("wrap0_state", 32'(sw_if.state_o), 32'd1);
        check("wrap0_run", 32'(sw_if.run), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button-driven sequencer for the 4-digit stopwatch datapath (centiseconds/seconds mod counters).
- Turns debounced start/stop and lap/reset buttons into the datapath `run` enable and a synchronous clear.
- Freezes the displayed value during a lap while the counters keep running.
- Sits between the debouncers and the stopwatch instance; its display outputs feed the seven-segment driver.

Parameters:
- DIGIT_W, 4: width of each BCD digit bus.
- CLEAR_CYCLES, 2: cycles `sw_clear` is held high per clear request; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_ss  input  1  start/stop button level; debounced and synchronised upstream
- btn_lr  input  1  lap/reset button level; debounced and synchronised upstream
- live0..live3  input  DIGIT_W each  live digits from the stopwatch; live0 least significant
- run  output  1  count enable to the stopwatch
- sw_clear  output  1  synchronous clear to the stopwatch; ORed with `reset` at the top level
- disp0..disp3  output  DIGIT_W each  digits to the display
- lap_active  output  1  high while the display is frozen
- state_o  output  2  encoded state for LEDs: IDLE=0, RUNNING=1, LAP=2, STOPPED=3

Behaviour:
- Reset is asynchronous. While `reset` is high:
  - state=IDLE; run=0; sw_clear=0; lap_active=0.
  - Held digit registers=0; clear counter=0.
  - Button-history registers=1, so a button held through reset does not produce a press.
- Press detection: a press is `btn` high while its history register is low. History registers update every cycle. One press event per rising level; holding a button generates nothing further.
- State changes on the same clock edge at which the press is sampled.
- `run`, `lap_active` and `state_o` are pure decodes of the state register, so they are valid the cycle after that edge.
- Transitions (if both presses arrive in the same cycle, `btn_ss` wins and the `btn_lr` press is discarded):
  - IDLE: ss -> RUNNING; lr -> stay IDLE and start a clear.
  - RUNNING: ss -> STOPPED; lr -> LAP and capture live0..live3 into the held registers on that edge.
  - LAP: ss -> STOPPED (lap released, display live); lr -> RUNNING (lap released).
  - STOPPED: ss -> RUNNING; lr -> IDLE and start a clear.
- `run` = 1 in RUNNING and LAP, 0 otherwise.
- Display mux: disp = held registers when in LAP, otherwise live digits. The held registers keep their value after the lap is released, but it is not shown.
- Clear sequencing:
  - A clear loads the counter with CLEAR_CYCLES.
  - `sw_clear` is high while the counter is non-zero; the counter decrements each cycle.
  - `sw_clear` is high for exactly CLEAR_CYCLES cycles, starting the cycle after the press edge.
  - While the counter is non-zero, all presses are ignored (dropped, not queued); history registers still update.
  - A clear press arriving during an active clear does not retrigger it.
- Reset asserted mid-clear or mid-lap aborts immediately to the reset values.
- Counter wrap: when the datapath rolls from 5999 to 0000 (without MAX_STOP_EN), the controller takes no action and stays in its state.

Optional Feature:
- Macro: STOPWATCH_MAX_STOP_EN
- Defined: in RUNNING or LAP, when live3..live0 equal 5,9,9,9, the state goes to STOPPED on the next edge.
  - Lap is released; run=0 the following cycle.
  - The datapath may advance at most one count past 5999 only if its tick coincides with that edge.
  - Any `btn_ss` press in that same cycle is ignored in favour of the auto-stop.
- Undefined: no comparison logic; the datapath wraps freely.

Test Plan:
- Reset held with btn_ss=1, then released -> state_o=0, run=0, no transition on the first edge; releasing and re-pressing btn_ss -> state_o=1, run=1 one cycle after the press edge.
- Live=0123 in RUNNING, press btn_lr -> lap_active=1, disp stays 0123 while live advances to 0150; press btn_lr again -> disp follows live, state_o=1.
- RUNNING, press btn_ss -> STOPPED, run=0; press btn_lr -> IDLE, sw_clear high exactly 2 cycles (CLEAR_CYCLES=2); btn_ss pressed during those cycles -> ignored, state stays 0.
- RUNNING, btn_ss and btn_lr rise in the same cycle -> STOPPED, no lap capture, lap_active=0.
- LAP with held 0042, assert reset asynchronously mid-cycle -> run, lap_active and sw_clear fall immediately; disp shows live; held registers=0.
- STOPWATCH_MAX_STOP_EN defined, live driven 5998->5999 while RUNNING -> state_o=3 and run=0 one cycle later; macro undefined -> state stays 1 through the wrap to 0000.
